// File: rtl/sorted_stream_reader_pkg.sv
// Shared definitions for the day08 sort-memory read-out path.
// Holds the default geometry of the sort RAM and the read-out FSM state type.
package sorted_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_DATA_ADDR_BITS = 10;
  localparam int DEF_MAX_NUM_VALUES = 1 << DEF_DATA_ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry registered FIFO for valid/ready stream stages.
// The head entry always lives in head_data, so downstream outputs come straight
// from a flop. A push while full is dropped unless a pop happens in the same cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          synchronous flush (empties the FIFO)
//   push/push_data write an entry
//   pop            remove the head entry (ignored when empty)
//   count          number of stored entries (0..2)
//   head_valid     count != 0
//   head_data      oldest stored entry
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] slot1;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok     = pop && (count != 2'd0);
  assign push_ok    = push && ((count != 2'd2) || pop_ok);
  assign head_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count     <= 2'd0;
      head_data <= '0;
      slot1     <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               slot1     <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= slot1;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new entry lands behind whatever remains.
          if (count == 2'd2) begin
            head_data <= slot1;
            slot1     <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sorted_stream_reader.sv
// sorted_stream_reader: read-out end of the day08 sort memory.
// After start, reads n = min(num_values, MAX_NUM_VALUES) entries from RAM port A
// (address 0 upward) and emits them as a valid/ready stream, tagging each beat with
// its RAM address and a last flag. It also flags (sticky) any entry that is smaller
// than the one streamed before it.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, num_values                 job request (sampled in IDLE only)
//   data_r_addr, data_r_en            RAM read request
//   data_r_data                       RAM read data, one cycle after the request
//   out_valid, out_ready              stream handshake
//   out_data, out_index, out_last     stream payload
//   busy, done, order_error           status
module sorted_stream_reader
  import sorted_stream_reader_pkg::*;
#(
  parameter int MAX_NUM_VALUES = DEF_MAX_NUM_VALUES,
  parameter int DATA_ADDR_BITS = DEF_DATA_ADDR_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_ADDR_BITS:0]   num_values,
  output logic [DATA_ADDR_BITS-1:0] data_r_addr,
  output logic                      data_r_en,
  input  logic [DATA_WIDTH-1:0]     data_r_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DATA_ADDR_BITS-1:0] out_index,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      order_error
);

  // The count/address width has one extra bit so that n == 2**DATA_ADDR_BITS
  // compares correctly against the address counter.
  localparam int               CNT_W = DATA_ADDR_BITS + 1;
  localparam int               PAY_W = 1 + DATA_ADDR_BITS + DATA_WIDTH;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_NUM_VALUES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
    return (req > MAX_N) ? MAX_N : req;
  endfunction

  state_t                    state;
  logic [CNT_W-1:0]          n_q;
  logic [CNT_W-1:0]          addr_q;
  logic [DATA_ADDR_BITS-1:0] last_addr_q;
  logic [CNT_W-1:0]          n_req;
  logic                      start_ok;
  logic                      pop;
  logic                      rd_en;
  logic [2:0]                occupancy;

  logic                      vld_p1;
  logic [DATA_ADDR_BITS-1:0] idx_p1;
  logic                      last_p1;

  logic [1:0]                fifo_count;
  logic                      head_valid;
  logic [PAY_W-1:0]          head_pay;
  logic [DATA_WIDTH-1:0]     prev_p2;

  assign n_req    = clamp_count(num_values);
  assign start_ok = start && (state == ST_IDLE);
  assign pop      = head_valid && out_ready;

  // Buffered entries plus the read still in flight must fit in the 2-entry FIFO,
  // counting the slot freed by a handshake in this same cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1};
  assign rd_en     = (state == ST_RUN) && (occupancy < (3'd2 + {2'b00, pop}));

  assign data_r_en   = rd_en;
  assign data_r_addr = rd_en ? addr_q[DATA_ADDR_BITS-1:0] : last_addr_q;

  // ---- stage p0 -> p1: read issued, RAM data arrives next cycle ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_en;
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      idx_p1  <= addr_q[DATA_ADDR_BITS-1:0];
      last_p1 <= (addr_q == (n_q - ONE));
    end
  end

  // ---- stage p1 -> p2: RAM data captured into the output FIFO ----
  stream_fifo2 #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (start_ok),
    .push       (vld_p1),
    .push_data  ({last_p1, idx_p1, data_r_data}),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_pay)
  );

  assign out_valid                       = head_valid;
  assign {out_last, out_index, out_data} = head_pay;

  // ---- stage p2: handshake, order check against the previous accepted word ----
  always_ff @(posedge clk) begin
    if (pop) prev_p2 <= out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      order_error <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q         <= n_req;
            addr_q      <= '0;
            order_error <= 1'b0;
            busy        <= 1'b1;
            state       <= (n_req == '0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            addr_q      <= addr_q + ONE;
            last_addr_q <= addr_q[DATA_ADDR_BITS-1:0];
            if (addr_q == (n_q - ONE)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          // Coming from DRAIN, done is already high here. An empty job enters
          // FINISH with done low and raises it one cycle later.
          if (done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (pop && (out_index != '0) && (out_data < prev_p2)) order_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sorted_stream_reader.sv
// Testbench for sorted_stream_reader: RAM model with 1-cycle synchronous read,
// randomized data and backpressure, reference expectations computed from the
// RAM contents and the stream rules.
module tb_sorted_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] num_values;
  logic [9:0]  data_r_addr;
  logic        data_r_en;
  logic [63:0] data_r_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [9:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        order_error;

  logic [63:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  // Per-job observations
  int k_first_valid, k_done, done_cnt, rd_cnt, hs_cnt, valid_cyc;
  int max_ahead, stall_err, addr_err, oe_rise;
  bit oe_k1, busy_k1, oe_final, timed_out;
  logic [63:0] q_data [$];
  int          q_idx  [$];
  bit          q_last [$];

  sorted_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_values  (num_values),
    .data_r_addr (data_r_addr),
    .data_r_en   (data_r_en),
    .data_r_data (data_r_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .order_error (order_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_r_en) data_r_data <= mem[data_r_addr];
  end

  function automatic logic ready_of(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_sorted(input int n);
    logic [63:0] v;
    v = {32'($urandom), 32'($urandom)} >> 4;
    for (int i = 0; i < n; i++) begin
      mem[i] = v;
      v = v + 64'($urandom_range(0, 2));
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = {32'($urandom), 32'($urandom)};
  endtask

  // Reference: 1 + index of the first entry smaller than its predecessor (the
  // handshake count after which order_error must be visible), or -1 if sorted.
  function automatic int model_first_desc(input int n);
    for (int i = 1; i < n; i++) if (mem[i] < mem[i-1]) return i + 1;
    return -1;
  endfunction

  // Runs one job: pulses start in cycle 0, then observes cycles 1..budget.
  task automatic run_job(input int nv, input int rmode, input int restart_k, input int budget);
    int k;
    bit prev_stall;
    logic [74:0] prev_pay;
    k_first_valid = -1; k_done = -1; done_cnt = 0; rd_cnt = 0; hs_cnt = 0;
    valid_cyc = 0; max_ahead = 0; stall_err = 0; addr_err = 0; oe_rise = -1;
    q_data.delete(); q_idx.delete(); q_last.delete();
    prev_stall = 1'b0; prev_pay = '0;
    @(negedge clk);
    start = 1'b1; num_values = 11'(nv); out_ready = ready_of(rmode, 0);
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      k++;
      start = (k == restart_k);
      if (k == restart_k) num_values = 11'd5;
      out_ready = ready_of(rmode, k);
      #1;
      if (k == 1) begin oe_k1 = order_error; busy_k1 = busy; end
      if (data_r_en) begin
        if (int'(data_r_addr) != rd_cnt) addr_err++;
        rd_cnt++;
      end
      if (out_valid) begin
        valid_cyc++;
        if (k_first_valid < 0) k_first_valid = k;
      end
      if (prev_stall && (!out_valid || {out_last, out_index, out_data} !== prev_pay)) stall_err++;
      if (order_error && oe_rise < 0) oe_rise = hs_cnt;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data); q_idx.push_back(int'(out_index)); q_last.push_back(out_last);
        hs_cnt++;
      end
      if (rd_cnt - hs_cnt > max_ahead) max_ahead = rd_cnt - hs_cnt;
      prev_stall = out_valid && !out_ready;
      prev_pay   = {out_last, out_index, out_data};
      if (done) begin
        done_cnt++;
        if (k_done < 0) k_done = k;
      end
      if (k_done >= 0 && k >= k_done + 2) break;
    end
    timed_out = (k_done < 0);
    oe_final  = order_error;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_values = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, done, busy, order_error, data_r_en, out_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid/done/busy/oerr/ren/last=%b required 000000",
               {out_valid, done, busy, order_error, data_r_en, out_last});
    end
    checks++;
    if (data_r_addr !== 10'd0 || out_index !== 10'd0 || out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d idx=%0d data=%0h required all 0", data_r_addr, out_index, out_data);
    end
  endtask

  task automatic test_basic8;
    int nbad;
    for (int i = 0; i < 8; i++) mem[i] = 64'(i + 1);
    run_job(8, 0, -1, 40);
    nbad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == 7)) nbad++;
    checks++;
    if (q_data.size() != 8 || nbad != 0) begin
      errors++;
      $display("FAIL basic8_stream: beats=%0d wrong=%0d required beats=8 wrong=0", q_data.size(), nbad);
    end
    checks++;
    if (k_first_valid != 3) begin
      errors++; $display("FAIL basic8_first_valid: cycle %0d required 3", k_first_valid);
    end
    checks++;
    if (k_done != 11 || done_cnt != 1) begin
      errors++; $display("FAIL basic8_done: cycle %0d count %0d required cycle 11 count 1", k_done, done_cnt);
    end
    checks++;
    if (oe_final !== 1'b0 || busy_k1 !== 1'b1 || rd_cnt != 8 || addr_err != 0) begin
      errors++;
      $display("FAIL basic8_status: oerr=%b busy@1=%b reads=%0d addr_err=%0d required 0 1 8 0",
               oe_final, busy_k1, rd_cnt, addr_err);
    end
  endtask

  task automatic test_backpressure20;
    int nbad;
    fill_sorted(20);
    run_job(20, 1, -1, 200);
    nbad = 0;
    for (int i = 0; i < 20; i++)
      if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == 19)) nbad++;
    checks++;
    if (q_data.size() != 20 || nbad != 0) begin
      errors++;
      $display("FAIL bp20_stream: beats=%0d wrong=%0d required beats=20 wrong=0", q_data.size(), nbad);
    end
    checks++;
    if (stall_err != 0 || max_ahead > 2 || addr_err != 0) begin
      errors++;
      $display("FAIL bp20_flow: unstable=%0d max_ahead=%0d addr_err=%0d required 0 <=2 0",
               stall_err, max_ahead, addr_err);
    end
    checks++;
    if (done_cnt != 1 || oe_final !== 1'b0) begin
      errors++; $display("FAIL bp20_done: done_count=%0d oerr=%b required 1 0", done_cnt, oe_final);
    end
  endtask

  task automatic test_order_error;
    int exp_rise;
    mem[0] = 64'd5; mem[1] = 64'd9; mem[2] = 64'd7; mem[3] = 64'd10;
    exp_rise = model_first_desc(4);
    run_job(4, 0, -1, 30);
    checks++;
    if (oe_rise != exp_rise || oe_final !== 1'b1) begin
      errors++;
      $display("FAIL order_rise: seen after %0d beats final=%b required after %0d final=1", oe_rise, oe_final, exp_rise);
    end
    fill_sorted(5);
    run_job(5, 0, -1, 30);
    checks++;
    if (oe_k1 !== 1'b0 || oe_final !== 1'b0) begin
      errors++; $display("FAIL order_clear: oerr@1=%b final=%b required 0 0", oe_k1, oe_final);
    end
  endtask

  task automatic test_empty_and_clamp;
    int nbad;
    run_job(0, 0, -1, 20);
    checks++;
    if (rd_cnt != 0 || valid_cyc != 0) begin
      errors++; $display("FAIL empty_activity: reads=%0d valid_cycles=%0d required 0 0", rd_cnt, valid_cyc);
    end
    checks++;
    if (k_done != 2 || done_cnt != 1) begin
      errors++; $display("FAIL empty_done: cycle %0d count %0d required cycle 2 count 1", k_done, done_cnt);
    end
    fill_sorted(1024);
    run_job(1500, 0, -1, 1100);
    nbad = 0;
    for (int i = 0; i < 1024; i++)
      if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == 1023)) nbad++;
    checks++;
    if (q_data.size() != 1024 || nbad != 0) begin
      errors++;
      $display("FAIL clamp_stream: beats=%0d wrong=%0d required beats=1024 wrong=0", q_data.size(), nbad);
    end
    checks++;
    if (k_done != 1027 || done_cnt != 1) begin
      errors++; $display("FAIL clamp_done: cycle %0d count %0d required cycle 1027 count 1", k_done, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int hs, leak, nbad;
    bit found;
    fill_sorted(16);
    hs = 0; found = 1'b0; leak = 0;
    @(negedge clk);
    start = 1'b1; num_values = 11'd16; out_ready = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (hs < 5);
      #1;
      if (out_valid && !out_ready && out_index == 10'd5) begin found = 1'b1; break; end
      if (out_valid && out_ready) hs++;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_stall: beat 5 stall seen=%b required 1", found);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (out_valid || data_r_en) leak++;
    end
    checks++;
    if (leak != 0) begin
      errors++; $display("FAIL rstmid_quiet: active cycles=%0d required 0", leak);
    end
    mem[0] = 64'hA; mem[1] = 64'hB; mem[2] = 64'hB;
    run_job(3, 0, -1, 30);
    nbad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == 2)) nbad++;
    checks++;
    if (q_data.size() != 3 || nbad != 0 || k_done != 6 || oe_final !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart: beats=%0d wrong=%0d done@%0d oerr=%b required 3 0 6 0",
               q_data.size(), nbad, k_done, oe_final);
    end
  endtask

  task automatic test_restart_ignored;
    int nbad;
    fill_sorted(16);
    run_job(16, 0, 5, 60);
    nbad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == 15)) nbad++;
    checks++;
    if (q_data.size() != 16 || nbad != 0) begin
      errors++;
      $display("FAIL restart_stream: beats=%0d wrong=%0d required beats=16 wrong=0", q_data.size(), nbad);
    end
    checks++;
    if (done_cnt != 1 || k_done != 19) begin
      errors++; $display("FAIL restart_done: count %0d cycle %0d required count 1 cycle 19", done_cnt, k_done);
    end
  endtask

  task automatic test_random;
    int n, nbad, exp_rise;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 40);
      if (it % 2 == 0) fill_sorted(n);
      else             fill_random(n);
      exp_rise = model_first_desc(n);
      run_job(n, 2, -1, 400);
      nbad = 0;
      for (int i = 0; i < n; i++)
        if (i >= q_data.size() || q_data[i] !== mem[i] || q_idx[i] != i || q_last[i] != (i == n - 1)) nbad++;
      checks++;
      if (q_data.size() != n || nbad != 0) begin
        errors++;
        $display("FAIL rand%0d_stream: beats=%0d wrong=%0d required beats=%0d wrong=0", it, q_data.size(), nbad, n);
      end
      checks++;
      if (oe_final !== (exp_rise > 0) || oe_rise != exp_rise) begin
        errors++;
        $display("FAIL rand%0d_order: oerr=%b rise=%0d required %b %0d", it, oe_final, oe_rise, exp_rise > 0, exp_rise);
      end
      checks++;
      if (done_cnt != 1 || timed_out || stall_err != 0 || max_ahead > 2) begin
        errors++;
        $display("FAIL rand%0d_flow: done_count=%0d unstable=%0d max_ahead=%0d required 1 0 <=2",
                 it, done_cnt, stall_err, max_ahead);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic8();
    test_backpressure20();
    test_order_error();
    test_empty_and_clamp();
    test_reset_mid();
    test_restart_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
